// File: rtl/mem_sequencer.sv
// Serialises four CPU read ports and one write port onto a single-port synchronous RAM.
// Latency: 1 + k + (k>0) + w stall cycles per service (k reads, w write), then one DONE cycle.
// Backpressure: stall is held high towards the CPU until all read data is captured and the write is issued.
module mem_sequencer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_inaddr,
    input  logic [DATA_W-1:0] m_indata,
    input  logic              m_read1,
    input  logic              m_read2,
    input  logic              m_read3,
    input  logic              m_read4,
    input  logic [ADDR_W-1:0] m_outaddr1,
    input  logic [ADDR_W-1:0] m_outaddr2,
    input  logic [ADDR_W-1:0] m_outaddr3,
    input  logic [ADDR_W-1:0] m_outaddr4,
    output logic [DATA_W-1:0] m_outdata1,
    output logic [DATA_W-1:0] m_outdata2,
    output logic [DATA_W-1:0] m_outdata3,
    output logic [DATA_W-1:0] m_outdata4,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        D_SEQSTATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Live request view; bit 0 is read port 1.
    logic [3:0] live_rd;
    logic       live_any;
    assign live_rd  = {m_read4, m_read3, m_read2, m_read1};
    assign live_any = (|live_rd) | m_write;

    // Snapshot of the request. pend_q holds the reads not yet issued and
    // shrinks by one bit per READ cycle.
    logic [3:0]        pend_q, pend_d;
    logic              snap_w_q;
    logic [ADDR_W-1:0] snap_raddr_q [4];
    logic [ADDR_W-1:0] snap_waddr_q;
    logic [DATA_W-1:0] snap_wdata_q;

    logic       take_snap;
    logic       issue_rd;
    logic [1:0] rd_sel;

    // Which port the RAM data arriving this cycle belongs to.
    logic       cap_vld_q;
    logic [1:0] cap_port_q;

    logic [DATA_W-1:0] outdata_q [4];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, RAM strobes and stall; everything is forced quiet while rst is high.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        take_snap = 1'b0;
        issue_rd  = 1'b0;
        stall     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = snap_waddr_q;
        ram_wdata = snap_wdata_q;

        // Lowest-numbered pending port goes first.
        if (pend_q[0])      rd_sel = 2'd0;
        else if (pend_q[1]) rd_sel = 2'd1;
        else if (pend_q[2]) rd_sel = 2'd2;
        else                rd_sel = 2'd3;

        case (state_q)
            S_IDLE: begin
                stall = live_any;
                if (live_any) begin
                    take_snap = 1'b1;
                    pend_d    = live_rd;
                    state_d   = (|live_rd) ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                stall    = 1'b1;
                ram_en   = 1'b1;
                issue_rd = 1'b1;
                ram_addr = snap_raddr_q[rd_sel];
                pend_d   = pend_q & ~(4'b0001 << rd_sel);
                if (pend_d == 4'b0000) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last read's data lands at the end of this cycle.
                stall   = 1'b1;
                state_d = snap_w_q ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                stall   = 1'b1;
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            stall     = 1'b0;
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            issue_rd  = 1'b0;
            take_snap = 1'b0;
        end
    end

    // Request snapshot and pending-read bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            snap_w_q     <= 1'b0;
            snap_waddr_q <= '0;
            snap_wdata_q <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_raddr_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            if (take_snap) begin
                snap_w_q        <= m_write;
                snap_waddr_q    <= m_inaddr;
                snap_wdata_q    <= m_indata;
                snap_raddr_q[0] <= m_outaddr1;
                snap_raddr_q[1] <= m_outaddr2;
                snap_raddr_q[2] <= m_outaddr3;
                snap_raddr_q[3] <= m_outaddr4;
            end
        end
    end

    // Remember the port of the read issued this cycle so its data is steered next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            cap_port_q <= 2'd0;
        end else begin
            cap_vld_q  <= issue_rd;
            cap_port_q <= rd_sel;
        end
    end

    // Held read-data registers; only the port whose data is arriving is updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                outdata_q[i] <= '0;
            end
        end else if (cap_vld_q) begin
            outdata_q[cap_port_q] <= ram_rdata;
        end
    end

    assign m_outdata1 = outdata_q[0];
    assign m_outdata2 = outdata_q[1];
    assign m_outdata3 = outdata_q[2];
    assign m_outdata4 = outdata_q[3];
    assign D_SEQSTATE = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: RAM environment plus a transaction-level reference model.
// Each service is predicted as an access list, state trace, stall count and read results.
// Requests are held by the bench until DONE, like a CPU frozen by stall.
module tb_mem_sequencer;
    localparam int AW = 14;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_write;
    logic [AW-1:0] m_inaddr;
    logic [DW-1:0] m_indata;
    logic          m_read1, m_read2, m_read3, m_read4;
    logic [AW-1:0] m_outaddr1, m_outaddr2, m_outaddr3, m_outaddr4;
    logic [DW-1:0] m_outdata1, m_outdata2, m_outdata3, m_outdata4;
    logic          stall;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [2:0]    D_SEQSTATE;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram       [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_out   [4];

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    always #5 clk = ~clk;

    mem_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_write    (m_write),
        .m_inaddr   (m_inaddr),
        .m_indata   (m_indata),
        .m_read1    (m_read1),
        .m_read2    (m_read2),
        .m_read3    (m_read3),
        .m_read4    (m_read4),
        .m_outaddr1 (m_outaddr1),
        .m_outaddr2 (m_outaddr2),
        .m_outaddr3 (m_outaddr3),
        .m_outaddr4 (m_outaddr4),
        .m_outdata1 (m_outdata1),
        .m_outdata2 (m_outdata2),
        .m_outdata3 (m_outdata3),
        .m_outdata4 (m_outdata4),
        .stall      (stall),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .D_SEQSTATE (D_SEQSTATE)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    task automatic clear_req();
        m_read1 = 0; m_read2 = 0; m_read3 = 0; m_read4 = 0; m_write = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram[a] = d;
        model_mem[a] = d;
    endtask

    // One complete service: predict, drive at the IDLE cycle, trace until DONE, compare.
    task automatic run_service(input string tag, input logic [3:0] rd,
                               input logic [3:0][AW-1:0] ra, input logic w,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        acc_t          exp_acc[$], act_acc[$];
        logic [2:0]    exp_st[$], act_st[$];
        acc_t          a;
        int            k, exp_stall, act_stall, bad_idx;
        logic [DW-1:0] act[4];
        bit            done;

        // Reference model: reads in port order, then the write; reads see pre-write memory.
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (rd[i]) begin
                k++;
                a.we = 1'b0; a.addr = ra[i]; a.data = '0;
                exp_acc.push_back(a);
                exp_out[i] = model_mem[ra[i]];
            end
        end
        if (w) begin
            a.we = 1'b1; a.addr = wa; a.data = wd;
            exp_acc.push_back(a);
            model_mem[wa] = wd;
        end
        exp_st.push_back(3'd0);
        for (int i = 0; i < k; i++) exp_st.push_back(3'd1);
        if (k > 0) exp_st.push_back(3'd2);
        if (w) exp_st.push_back(3'd3);
        exp_st.push_back(3'd4);
        exp_stall = exp_st.size() - 1;

        @(negedge clk);
        m_read1 = rd[0]; m_read2 = rd[1]; m_read3 = rd[2]; m_read4 = rd[3];
        m_outaddr1 = ra[0]; m_outaddr2 = ra[1]; m_outaddr3 = ra[2]; m_outaddr4 = ra[3];
        m_write = w; m_inaddr = wa; m_indata = wd;

        act_stall = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c == 0) #1;
            else @(negedge clk);
            act_st.push_back(D_SEQSTATE);
            if (stall) act_stall++;
            if (ram_en) begin
                a.we = ram_we; a.addr = ram_addr; a.data = ram_we ? ram_wdata : '0;
                act_acc.push_back(a);
            end
            if (D_SEQSTATE == 3'd4) done = 1;
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_timeout got state %0d after 20 cycles, required state 4", tag, D_SEQSTATE);
        end
        checks++;
        if (act_stall !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d required %0d", tag, act_stall, exp_stall);
        end
        bad_idx = -1;
        for (int i = 0; i < exp_st.size(); i++)
            if (bad_idx < 0 && (i >= act_st.size() || act_st[i] !== exp_st[i])) bad_idx = i;
        if (bad_idx < 0 && act_st.size() != exp_st.size()) bad_idx = exp_st.size();
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s state_trace differs at step %0d: got len %0d required len %0d (required state %0d)",
                     tag, bad_idx, act_st.size(), exp_st.size(),
                     (bad_idx < exp_st.size()) ? exp_st[bad_idx] : 3'd0);
        end
        bad_idx = -1;
        for (int i = 0; i < exp_acc.size(); i++)
            if (bad_idx < 0 && (i >= act_acc.size() || act_acc[i] !== exp_acc[i])) bad_idx = i;
        if (bad_idx < 0 && act_acc.size() != exp_acc.size()) bad_idx = exp_acc.size();
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s ram_access differs at access %0d: got %0d accesses, required %0d (got %h required %h)",
                     tag, bad_idx, act_acc.size(), exp_acc.size(),
                     (bad_idx < act_acc.size()) ? act_acc[bad_idx] : '0,
                     (bad_idx < exp_acc.size()) ? exp_acc[bad_idx] : '0);
        end
        act[0] = m_outdata1; act[1] = m_outdata2; act[2] = m_outdata3; act[3] = m_outdata4;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== exp_out[i]) begin
                errors++;
                $display("FAIL %s outdata%0d got %h required %h", tag, i + 1, act[i], exp_out[i]);
            end
        end
        clear_req();
    endtask

    task automatic test_reset();
        logic [DW-1:0] act[4];
        rst = 1;
        clear_req();
        m_inaddr = '0; m_indata = '0;
        m_outaddr1 = '0; m_outaddr2 = '0; m_outaddr3 = '0; m_outaddr4 = '0;
        for (int i = 0; i < 4; i++) exp_out[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_read1 = 1; m_write = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b ram_en=%b ram_we=%b required 0/0/0", stall, ram_en, ram_we);
        end
        checks++;
        if (D_SEQSTATE !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d required 0", D_SEQSTATE);
        end
        act[0] = m_outdata1; act[1] = m_outdata2; act[2] = m_outdata3; act[3] = m_outdata4;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== '0) begin
                errors++;
                $display("FAIL reset_outdata%0d got %h required 0", i + 1, act[i]);
            end
        end
        clear_req();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_fetch();
        logic [3:0][AW-1:0] ra;
        preload(14'h2000, 10'h155); preload(14'h2001, 10'h0AA); preload(14'h2002, 10'h3FF);
        ra[0] = 14'h2000; ra[1] = 14'h2001; ra[2] = 14'h2002; ra[3] = 14'h0000;
        run_service("fetch", 4'b0111, ra, 1'b0, '0, '0);
    endtask

    task automatic test_write_only();
        logic [3:0][AW-1:0] ra;
        ra = '0;
        run_service("write_only", 4'b0000, ra, 1'b1, 14'h0010, 10'h123);
        checks++;
        if (ram[14'h0010] !== 10'h123) begin
            errors++;
            $display("FAIL write_only_mem got %h required 123", ram[14'h0010]);
        end
    endtask

    task automatic test_read4_write_same();
        logic [3:0][AW-1:0] ra;
        preload(14'h0040, 10'h011);
        ra = '0; ra[3] = 14'h0040;
        run_service("rd4_wr_same", 4'b1000, ra, 1'b1, 14'h0040, 10'h022);
        checks++;
        if (ram[14'h0040] !== 10'h022) begin
            errors++;
            $display("FAIL rd4_wr_same_mem got %h required 022", ram[14'h0040]);
        end
    endtask

    task automatic test_all_reads_write();
        logic [3:0][AW-1:0] ra;
        ra[0] = 14'h0300; ra[1] = 14'h0301; ra[2] = 14'h0302; ra[3] = 14'h1234;
        run_service("all_rw", 4'b1111, ra, 1'b1, 14'h0301, 10'h2C7);
    endtask

    // Halted CPU: identical requests presented again straight after DONE.
    task automatic test_back_to_back();
        logic [3:0][AW-1:0] ra;
        ra[0] = 14'h0500; ra[1] = 14'h0501; ra[2] = 14'h0502; ra[3] = 14'h0500;
        run_service("b2b_a", 4'b1011, ra, 1'b1, 14'h0502, 10'h19E);
        run_service("b2b_b", 4'b1011, ra, 1'b1, 14'h0502, 10'h19E);
        run_service("b2b_c", 4'b0000, ra, 1'b1, 14'h0600, 10'h0F0);
        run_service("b2b_d", 4'b0000, ra, 1'b1, 14'h0600, 10'h0F0);
    endtask

    task automatic test_random();
        logic [3:0][AW-1:0] ra;
        logic [3:0]         rd;
        logic               w;
        for (int n = 0; n < 30; n++) begin
            rd = 4'($urandom_range(0, 15));
            w  = 1'($urandom_range(0, 1));
            if (rd == 4'b0000) w = 1'b1;
            for (int i = 0; i < 4; i++) ra[i] = AW'(14'h0100 + $urandom_range(0, 7));
            run_service("random", rd, ra, w, AW'(14'h0100 + $urandom_range(0, 7)), DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0 || ram_en !== 1'b0 || D_SEQSTATE !== 3'd0 ||
                m_outdata1 !== exp_out[0] || m_outdata2 !== exp_out[1] ||
                m_outdata3 !== exp_out[2] || m_outdata4 !== exp_out[3]) begin
                errors++;
                $display("FAIL idle cycle %0d got stall=%b ram_en=%b state=%0d out=%h/%h/%h/%h required 0/0/0 out=%h/%h/%h/%h",
                         c, stall, ram_en, D_SEQSTATE, m_outdata1, m_outdata2, m_outdata3, m_outdata4,
                         exp_out[0], exp_out[1], exp_out[2], exp_out[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] act[4];
        @(negedge clk);
        m_read1 = 1; m_read2 = 1; m_read3 = 1; m_read4 = 1;
        m_outaddr1 = 14'h2000; m_outaddr2 = 14'h2001; m_outaddr3 = 14'h2002; m_outaddr4 = 14'h0040;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (D_SEQSTATE !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_pre_state got %0d required 1", D_SEQSTATE);
        end
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_during got stall=%b ram_en=%b required 0/0", stall, ram_en);
        end
        @(negedge clk);
        checks++;
        if (D_SEQSTATE !== 3'd0 || ram_en !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after got state=%0d ram_en=%b stall=%b required 0/0/0", D_SEQSTATE, ram_en, stall);
        end
        act[0] = m_outdata1; act[1] = m_outdata2; act[2] = m_outdata3; act[3] = m_outdata4;
        for (int i = 0; i < 4; i++) begin
            exp_out[i] = '0;
            checks++;
            if (act[i] !== '0) begin
                errors++;
                $display("FAIL rst_mid_outdata%0d got %h required 0", i + 1, act[i]);
            end
        end
        rst = 0;
        clear_req();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = DW'($urandom);
            model_mem[i] = ram[i];
        end
        test_reset();
        test_fetch();
        test_write_only();
        test_read4_write_same();
        test_all_reads_write();
        test_back_to_back();
        test_idle();
        test_random();
        test_reset_mid();
        test_fetch();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Serialises the CPU's four read ports and one write port onto a single-port synchronous RAM with one-cycle read latency. Sits directly downstream of the `cpu` block. It drives `stall` back to the CPU so that the CPU's gated clock freezes while multi-access requests are serviced. It returns all read data in held registers before releasing the stall.

## Interface
Parameters:
- `ADDR_W`, 14, address width of every port and of the RAM.
- `DATA_W`, 10, data width of every port and of the RAM.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m_write`  in  1  CPU write request.
- `m_inaddr`  in  ADDR_W  write address.
- `m_indata`  in  DATA_W  write data.
- `m_read1`..`m_read4`  in  1 each  CPU read requests, ports 1–4.
- `m_outaddr1`..`m_outaddr4`  in  ADDR_W each  read addresses.
- `m_outdata1`..`m_outdata4`  out  DATA_W each  held read data, one register per port.
- `stall`  out  1  freezes the CPU while high.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable; valid only with `ram_en`.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after a read strobe.
- `D_SEQSTATE`  out  3  debug view of the FSM state.

## Operation
- The request vector is {r1,r2,r3,r4,w}. At entry to service, the vector and all addresses and write data are snapshotted into registers. All RAM traffic uses the snapshot.
- FSM states and encodings: IDLE=0, READ=1, DRAIN=2, WRITE=3, DONE=4.
  - IDLE: `stall` = OR of the live request vector (combinational). If the vector is nonzero, take the snapshot and go to READ when any read is set, else to WRITE. Issues no RAM access.
  - READ: issues one read per cycle to the enabled ports, in order 1,2,3,4, skipping disabled ports. After the last enabled read is issued, go to DRAIN. `stall`=1.
  - DRAIN: no new access; the last read's data is captured at the end of this cycle. Go to WRITE if w is set, else to DONE. `stall`=1.
  - WRITE: `ram_en`=`ram_we`=1, with `ram_addr`/`ram_wdata` taken from the snapshot. Go to DONE. `stall`=1.
  - DONE: `stall`=0, so the CPU advances on this edge. Always go to IDLE.
- Read capture: data for a read issued in cycle t is written into that port's `m_outdataN` register at the end of cycle t+1. Registers of ports not requested keep their previous values.
- Ordering: all reads precede the write. When read port 4 and the write target the same address, `m_outdata4` returns the pre-write value.
- `m_outdataN` is stable from DONE until overwritten by a later capture.
- Outside READ and WRITE, `ram_en`=`ram_we`=0. The values of `ram_addr`/`ram_wdata` are don't-care when `ram_en`=0.
- Address arithmetic is the CPU's concern; addresses are used unmodified. No wrap logic is needed.

## Timing
- Let k = number of enabled reads (0–4) and w = the write bit.
- `stall` high cycles per service: 1 (IDLE) + k + (1 if k>0) + w. This is followed by exactly one DONE cycle with `stall`=0.
- Examples: fetch only = 5 high cycles; write only = 2; four reads plus write = 7.
- Back-to-back: DONE is always followed by IDLE. New requests presented in that IDLE cycle raise `stall` in the same cycle.
- Unchanged requests after DONE (for example, a halted CPU) are serviced again. A repeated write is idempotent.
- Reset values:
  - state IDLE; all `m_outdataN` = 0; snapshot registers = 0.
  - `ram_en`=`ram_we`=0.
  - `stall`=0 while `rst` is high, regardless of requests.
- Reset asserted mid-service: next cycle is IDLE, and an in-flight read's data is discarded.

## Test plan
- Fetch only: r1–r3 at 0x2000/0x2001/0x2002 with RAM contents 0x155/0x0AA/0x3FF -> `stall` high 5 cycles; `ram_addr` sequence 0x2000, 0x2001, 0x2002; in DONE, outdata1..3 = 0x155/0x0AA/0x3FF.
- Write only: w, addr 0x0010, data 0x123 -> `stall` high 2 cycles; exactly one cycle with `ram_we`=1, `ram_addr`=0x0010, `ram_wdata`=0x123; DONE follows.
- Read4 plus write to the same address 0x0040 holding 0x011, writing 0x022 -> `m_outdata4`=0x011; RAM[0x0040]=0x022 afterwards.
- All four reads plus write -> `stall` high 7 cycles; issue order pc, pc+1, pc+2, addr4, then the write; state sequence 0,1,1,1,1,2,3,4.
- Reset pulsed during the second READ cycle -> next cycle state=0, `ram_en`=0, all `m_outdataN`=0, `stall`=0 during `rst`.
- No requests for 20 cycles -> `stall`=0, `ram_en`=0, state stays 0, outputs unchanged.
